// File: rtl/perm_arb.sv
// perm_arb -- two-requester frame arbiter in front of a shared perm core.
//
// Purpose:
//   Grants one of two requesters ownership of the perm input for one
//   8-beat frame at a time. Round-robin on contention. Each completed frame
//   pushes its owner tag into an in-flight FIFO. Result beats from the perm
//   core are routed back to the requester at the FIFO head. A result beat
//   with index 7 retires that tag.
//
// Parameters:
//   TAGDEPTH  depth of the in-flight ownership-tag FIFO (2..8).
//
// Ports:
//   clk, reset                 clock (rising edge) and async active-low reset
//   rN_req / rN_gnt            frame request / registered grant, N = 0,1
//   rN_pushin / rN_din         beat valid / 200-bit beat data from requester N
//   p_pushin / p_dix / p_din   registered beat stream to the perm core
//   p_pushout/p_doutix/p_dout  result stream from the perm core
//   o_pushout0/1, o_doutix,
//   o_dout                     result stream routed to the owning requester
//   err                        sticky: result beat arrived with no tag queued
//   frames0/frames1            (PERM_ARB_STATS_EN only) 16-bit wrapping
//                              count of completed frames per requester
//
// Build option:
//   PERM_ARB_STATS_EN  when defined, adds the frames0/frames1 counters.
module perm_arb #(
    parameter int TAGDEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         r0_req,
    input  logic         r1_req,
    output logic         r0_gnt,
    output logic         r1_gnt,
    input  logic         r0_pushin,
    input  logic         r1_pushin,
    input  logic [199:0] r0_din,
    input  logic [199:0] r1_din,
    output logic         p_pushin,
    output logic [2:0]   p_dix,
    output logic [199:0] p_din,
    input  logic         p_pushout,
    input  logic [2:0]   p_doutix,
    input  logic [199:0] p_dout,
    output logic         o_pushout0,
    output logic         o_pushout1,
    output logic [2:0]   o_doutix,
    output logic [199:0] o_dout,
    output logic         err
`ifdef PERM_ARB_STATS_EN
    ,
    output logic [15:0]  frames0,
    output logic [15:0]  frames1
`endif
);

    localparam int PW = $clog2(TAGDEPTH);
    localparam int CW = $clog2(TAGDEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(TAGDEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(TAGDEPTH - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;      // requester served most recently
    logic [2:0]    beat_q, beat_d;

    logic          p_pushin_q;
    logic [2:0]    p_dix_q;
    logic [199:0]  p_din_q;
    logic          o_pushout0_q, o_pushout1_q;
    logic [2:0]    o_doutix_q;
    logic [199:0]  o_dout_q;
    logic          err_q;

    logic          fifo_q [TAGDEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;

    logic          in_grant, owner, accept, push, pop, route, head;
    logic          full_arb, any_req, pick1;
    logic [199:0]  acc_din;

    always_comb begin
        in_grant = (state_q == GRANT0) || (state_q == GRANT1);
        owner    = (state_q == GRANT1);
        // A beat from a requester without the grant is never accepted.
        accept   = ((state_q == GRANT0) && r0_pushin) ||
                   ((state_q == GRANT1) && r1_pushin);
        acc_din  = owner ? r1_din : r0_din;
        push     = accept && (beat_q == 3'd7);
        route    = p_pushout && (cnt_q != '0);
        pop      = route && (p_doutix == 3'd7);
        head     = fifo_q[rd_q];
        // Occupancy seen by the arbiter includes a same-cycle push but
        // ignores a same-cycle pop, so a freed slot is usable next cycle.
        full_arb = (cnt_q + CW'(push)) == DEPTH_C;
        any_req  = r0_req || r1_req;
        // On a tie the requester that was not served last wins.
        pick1    = r1_req && (!r0_req || !last_q);
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        beat_d  = beat_q;
        if (accept) begin
            beat_d = beat_q + 3'd1;
        end
        // Arbitrate from IDLE, or in the cycle the final beat is accepted
        // so a pending requester takes over without an IDLE bubble.
        if (!in_grant || push) begin
            if (any_req && !full_arb) begin
                state_d = pick1 ? GRANT1 : GRANT0;
                last_d  = pick1;
                beat_d  = 3'd0;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;            // requester 0 has priority after reset
            beat_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    // Beat stream to the perm core; index/data hold between beats.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_pushin_q <= 1'b0;
            p_dix_q    <= 3'd0;
            p_din_q    <= '0;
        end else begin
            p_pushin_q <= accept;
            if (accept) begin
                p_dix_q <= beat_q;
                p_din_q <= acc_din;
            end
        end
    end

    // Tag FIFO bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                wr_q <= (wr_q == LAST_PTR) ? '0 : wr_q + PW'(1);
            end
            if (pop) begin
                rd_q <= (rd_q == LAST_PTR) ? '0 : rd_q + PW'(1);
            end
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Tag storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_q] <= owner;
        end
    end

    // Result routing and the sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_pushout0_q <= 1'b0;
            o_pushout1_q <= 1'b0;
            o_doutix_q   <= 3'd0;
            o_dout_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            o_pushout0_q <= route && !head;
            o_pushout1_q <= route && head;
            if (route) begin
                o_doutix_q <= p_doutix;
                o_dout_q   <= p_dout;
            end
            if (p_pushout && (cnt_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef PERM_ARB_STATS_EN
    logic [15:0] frames0_q, frames1_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frames0_q <= 16'd0;
            frames1_q <= 16'd0;
        end else if (push) begin
            if (owner) begin
                frames1_q <= frames1_q + 16'd1;
            end else begin
                frames0_q <= frames0_q + 16'd1;
            end
        end
    end

    assign frames0 = frames0_q;
    assign frames1 = frames1_q;
`endif

    assign r0_gnt     = (state_q == GRANT0);
    assign r1_gnt     = (state_q == GRANT1);
    assign p_pushin   = p_pushin_q;
    assign p_dix      = p_dix_q;
    assign p_din      = p_din_q;
    assign o_pushout0 = o_pushout0_q;
    assign o_pushout1 = o_pushout1_q;
    assign o_doutix   = o_doutix_q;
    assign o_dout     = o_dout_q;
    assign err        = err_q;

endmodule

// File: tb/tb_perm_arb.sv
module tb_perm_arb;

    localparam int TAGDEPTH = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         r0_req = 1'b0, r1_req = 1'b0;
    logic         r0_pushin = 1'b0, r1_pushin = 1'b0;
    logic [199:0] r0_din = '0, r1_din = '0;
    logic         p_pushout = 1'b0;
    logic [2:0]   p_doutix = 3'd0;
    logic [199:0] p_dout = '0;
    logic         r0_gnt, r1_gnt, p_pushin, o_pushout0, o_pushout1, err;
    logic [2:0]   p_dix, o_doutix;
    logic [199:0] p_din, o_dout;
`ifdef PERM_ARB_STATS_EN
    logic [15:0]  frames0, frames1;
`endif

    perm_arb #(.TAGDEPTH(TAGDEPTH)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r1_req(r1_req),
        .r0_gnt(r0_gnt), .r1_gnt(r1_gnt),
        .r0_pushin(r0_pushin), .r1_pushin(r1_pushin),
        .r0_din(r0_din), .r1_din(r1_din),
        .p_pushin(p_pushin), .p_dix(p_dix), .p_din(p_din),
        .p_pushout(p_pushout), .p_doutix(p_doutix), .p_dout(p_dout),
        .o_pushout0(o_pushout0), .o_pushout1(o_pushout1),
        .o_doutix(o_doutix), .o_dout(o_dout),
        .err(err)
`ifdef PERM_ARB_STATS_EN
        , .frames0(frames0), .frames1(frames1)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct { logic [2:0] ix; logic [199:0] d; } pbeat_t;
    typedef struct { int own; logic [2:0] ix; logic [199:0] d; } obeat_t;

    // Scoreboard queues filled by stimulus, drained by monitors.
    pbeat_t p_exp[$];
    obeat_t o_exp[$];
    int     gnt_exp[$];

    // Reference model: in-flight owner tags, tie-break winner, error flag.
    int     tags[$];
    int     rr_next = 0;
    bit     err_model = 1'b0;
    bit     pend[2] = '{1'b0, 1'b0};

    logic [199:0] fixed_d[8];

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [199:0] rnd200();
        logic [199:0] v;
        v = '0;
        for (int i = 0; i < 7; i++) v = {v[167:0], 32'($urandom())};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitors ----------------
    pbeat_t pm_e;
    always @(negedge clk) begin
        if (p_pushin) begin
            if (p_exp.size() == 0) begin
                chk("p_unexpected_beat", {p_dix, p_din}, '0);
            end else begin
                pm_e = p_exp.pop_front();
                chk("p_dix", p_dix, pm_e.ix);
                chk("p_din", p_din, pm_e.d);
                $display("[TB] p beat dix=%0d din=%0h", p_dix, p_din);
            end
        end
    end

    obeat_t om_e;
    always @(negedge clk) begin
        if (o_pushout0 || o_pushout1) begin
            if (o_exp.size() == 0) begin
                chk("o_unexpected_beat", {o_pushout1, o_pushout0}, 2'b00);
            end else begin
                om_e = o_exp.pop_front();
                chk("o_pushout0", o_pushout0, om_e.own == 0);
                chk("o_pushout1", o_pushout1, om_e.own == 1);
                chk("o_doutix", o_doutix, om_e.ix);
                chk("o_dout", o_dout, om_e.d);
                $display("[TB] o beat to r%0d ix=%0d", om_e.own, o_doutix);
            end
        end
    end

    logic g0_prev = 1'b0, g1_prev = 1'b0;
    int   gm_e;
    always @(negedge clk) begin
        chk("gnt_onehot", r0_gnt & r1_gnt, 1'b0);
        if ((r0_gnt && !g0_prev) || (r1_gnt && !g1_prev)) begin
            if (gnt_exp.size() == 0) begin
                chk("gnt_unexpected", {r1_gnt, r0_gnt}, 2'b00);
            end else begin
                gm_e = gnt_exp.pop_front();
                chk("gnt_owner", {r1_gnt, r0_gnt}, (gm_e == 1) ? 2'b10 : 2'b01);
                $display("[TB] grant to r%0d", gm_e);
            end
        end
        g0_prev <= r0_gnt;
        g1_prev <= r1_gnt;
    end

    // ---------------- stimulus tasks ----------------
    task automatic request(input bit a0, input bit a1, output int w);
        int n;
        w = (a0 && a1) ? rr_next : (a1 ? 1 : 0);
        gnt_exp.push_back(w);
        if (a0) r0_req = 1'b1;
        if (a1) r1_req = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!((w == 0) ? r0_gnt : r1_gnt) && n < 100);
        chk("gnt_latency", n, 1);
        if (w == 0) r0_req = 1'b0; else r1_req = 1'b0;
        rr_next = 1 - w;
        pend[w] = 1'b0;
        if (a0 && a1) pend[1 - w] = 1'b1;
    endtask

    task automatic drive_req_push(input int r, input logic v, input logic [199:0] d);
        if (r == 0) begin r0_pushin = v; r0_din = d; end
        else        begin r1_pushin = v; r1_din = d; end
    endtask

    task automatic send_frame(input int w, input logic [7:0] gapmask, input bit use_fixed);
        logic [199:0] d;
        pbeat_t e;
        int nxt;
        for (int k = 0; k < 8; k++) begin
            if (gapmask[k]) begin
                drive_req_push(w, 1'b0, rnd200());
                drive_req_push(1 - w, 1'($urandom_range(0, 1)), rnd200());
                tick();
                chk("gnt_held", (w == 0) ? r0_gnt : r1_gnt, 1'b1);
            end
            d = use_fixed ? fixed_d[k] : rnd200();
            e.ix = 3'(k);
            e.d  = d;
            p_exp.push_back(e);
            drive_req_push(w, 1'b1, d);
            // The non-owner pushes noise that must be ignored.
            drive_req_push(1 - w, 1'($urandom_range(0, 1)), rnd200());
            tick();
        end
        r0_pushin = 1'b0;
        r1_pushin = 1'b0;
        tags.push_back(w);
        nxt = (pend[1 - w] && tags.size() < TAGDEPTH) ? 1 - w : -1;
        chk("gnt_after_frame", {r1_gnt, r0_gnt},
            (nxt < 0) ? 2'b00 : ((nxt == 0) ? 2'b01 : 2'b10));
        if (nxt >= 0) begin
            gnt_exp.push_back(nxt);
            if (nxt == 0) r0_req = 1'b0; else r1_req = 1'b0;
            pend[nxt] = 1'b0;
            rr_next = 1 - nxt;
        end
    endtask

    task automatic ret_frame(input logic [7:0] gapmask);
        logic [199:0] d;
        obeat_t e;
        for (int k = 0; k < 8; k++) begin
            if (gapmask[k]) begin
                p_pushout = 1'b0;
                tick();
            end
            d = rnd200();
            p_pushout = 1'b1;
            p_doutix  = 3'(k);
            p_dout    = d;
            if (tags.size() > 0) begin
                e.own = tags[0];
                e.ix  = 3'(k);
                e.d   = d;
                o_exp.push_back(e);
                if (k == 7) void'(tags.pop_front());
            end else begin
                err_model = 1'b1;
            end
            tick();
        end
        p_pushout = 1'b0;
        chk("err_flag", err, err_model);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_ctl"}, {r0_gnt, r1_gnt, p_pushin, p_dix, o_pushout0, o_pushout1,
                             o_doutix, err}, '0);
        chk({name, "_p_din"}, p_din, '0);
        chk({name, "_o_dout"}, o_dout, '0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int w;
        int n;
        fixed_d[0] = 200'h60a636261;
        fixed_d[1] = '0; fixed_d[2] = '0; fixed_d[3] = '0; fixed_d[4] = '0;
        fixed_d[5] = 200'h8000000000000000000000;
        fixed_d[6] = '0; fixed_d[7] = '0;

        repeat (3) tick();
        check_all_zero("reset_state");
        reset = 1'b1;
        tick();

        // Contention from reset: r0, then r1 without a bubble, then r0 again.
        request(1'b1, 1'b1, w);
        chk("contention_first", w, 0);
        send_frame(w, 8'h00, 1'b0);
        r0_req = 1'b1;
        pend[0] = 1'b1;
        send_frame(1, 8'h00, 1'b0);
        send_frame(0, 8'h00, 1'b0);
        // Result routing: owners r0, r1, r0 in order.
        repeat (3) ret_frame(8'h00);
        chk("err_after_routing", err, 1'b0);

        // Single frame with fixed payload.
        request(1'b1, 1'b0, w);
        send_frame(0, 8'h00, 1'b1);
        ret_frame(8'h00);

        // Gapped input on r1: three idle cycles inside the frame.
        request(1'b0, 1'b1, w);
        send_frame(1, 8'b0101_0100, 1'b0);
        ret_frame(8'h12);

        // FIFO full: four frames outstanding, fifth waits for a pop.
        for (int i = 0; i < TAGDEPTH; i++) begin
            request(i % 2 == 0, i % 2 == 1, w);
            send_frame(w, 8'($urandom()) & 8'h11, 1'b0);
        end
        r0_req = 1'b1;
        gnt_exp.push_back(0);
        repeat (6) begin
            tick();
            chk("full_no_gnt", {r1_gnt, r0_gnt}, 2'b00);
        end
        ret_frame(8'h00);
        chk("gnt_before_pop_visible", r0_gnt, 1'b0);
        n = 0;
        while (!r0_gnt && n < 50) begin tick(); n++; end
        chk("gnt_after_pop", n, 1);
        r0_req = 1'b0;
        rr_next = 1;
        send_frame(0, 8'h00, 1'b0);
        while (tags.size() > 0) ret_frame(8'h00);

        // Randomized mix of frames, contention and result returns.
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 2))
                0: if (tags.size() < TAGDEPTH) begin
                       n = $urandom_range(0, 1);
                       request(n == 0, n == 1, w);
                       send_frame(w, 8'($urandom()) & 8'h49, 1'b0);
                   end
                1: if (tags.size() <= TAGDEPTH - 2) begin
                       request(1'b1, 1'b1, w);
                       send_frame(w, 8'($urandom()) & 8'h24, 1'b0);
                       send_frame(1 - w, 8'($urandom()) & 8'h92, 1'b0);
                   end
                default: if (tags.size() > 0) ret_frame(8'($urandom()) & 8'h81);
            endcase
        end
        while (tags.size() > 0) ret_frame(8'h00);

        // Result beats with nothing in flight: dropped, err sets.
        chk("err_before_empty_ret", err, 1'b0);
        ret_frame(8'h00);
        chk("err_sticky", err, 1'b1);

        // Reset in the middle of a frame.
        request(1'b1, 1'b0, w);
        for (int k = 0; k < 3; k++) begin
            pbeat_t e;
            e.ix = 3'(k);
            e.d  = rnd200();
            p_exp.push_back(e);
            drive_req_push(0, 1'b1, e.d);
            tick();
        end
        r0_pushin = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #2;
        check_all_zero("midframe_reset");
        tags.delete();
        rr_next = 0;
        err_model = 1'b0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Priority back to r0 after reset.
        request(1'b1, 1'b1, w);
        chk("post_reset_first", w, 0);
        send_frame(0, 8'h00, 1'b0);
        send_frame(1, 8'h00, 1'b0);
        repeat (2) ret_frame(8'h00);

        tick();
        tick();
        chk("p_queue_drained", p_exp.size(), 0);
        chk("o_queue_drained", o_exp.size(), 0);
        chk("gnt_queue_drained", gnt_exp.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/perm_arb.md
PERM_ARB -- requirements
Module: perm_arb

Interface
REQ-001 SHALL have parameter TAGDEPTH, default 4, giving the depth of the in-flight ownership-tag FIFO (2..8).
REQ-002 SHALL have port clk  in  1  the single rising-edge clock for all state.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports r0_req, r1_req  in  1 each  requester N asks for one 8-beat frame slot.
REQ-005 SHALL have ports r0_gnt, r1_gnt  out  1 each  requester N owns the perm input for the current frame.
REQ-006 SHALL have ports r0_pushin, r1_pushin  in  1 each  beat valid from requester N.
REQ-007 SHALL have ports r0_din, r1_din  in  200 each  beat data from requester N.
REQ-008 SHALL have ports p_pushin  out  1, p_dix  out  3, p_din  out  200  beat stream to the perm core.
REQ-009 SHALL have ports p_pushout  in  1, p_doutix  in  3, p_dout  in  200  result stream from the perm core.
REQ-010 SHALL have ports o_pushout0, o_pushout1  out  1 each, o_doutix  out  3, o_dout  out  200  result stream routed to the owning requester.
REQ-011 SHALL have port err  out  1  sticky protocol-error flag.

Function
REQ-012 SHALL implement FSM states IDLE, GRANT0, GRANT1; exactly one of r0_gnt/r1_gnt is high in GRANTN, and neither is high in IDLE.
REQ-013 SHALL leave IDLE for GRANTN in the cycle after rN_req is sampled high and the tag FIFO is not full; gnt is registered.
REQ-014 SHALL arbitrate round-robin: on simultaneous requests the requester not served last wins; after reset, requester 0 has priority.
REQ-015 SHALL keep a 3-bit beat counter cleared at each grant; a beat is accepted when rN_pushin and rN_gnt are both high; the counter increments only on accepted beats.
REQ-016 SHALL register each accepted beat to the perm core one cycle later: p_pushin=1, p_dix=beat counter, p_din=rN_din; otherwise p_pushin=0 and p_dix/p_din hold.
REQ-017 SHALL hold the grant across idle (pushin=0) cycles; there is no grant timeout.
REQ-018 SHALL push the owner tag N into the FIFO when beat 7 is accepted, then re-arbitrate in the same cycle.
REQ-019 SHALL hand over directly to the next GRANT state without an IDLE bubble when a request is pending and the FIFO is not full.
REQ-020 SHALL evaluate FIFO full before any same-cycle pop; a full FIFO keeps the FSM in IDLE.
REQ-021 SHALL route each p_pushout beat, one cycle later, to o_pushoutT, where T is the FIFO head tag; o_doutix=p_doutix and o_dout=p_dout.
REQ-022 SHALL pop the FIFO on a p_pushout beat with p_doutix==7.
REQ-023 SHALL, on p_pushout with the FIFO empty, drop the beat (no o_pushout) and set err until reset.
REQ-024 SHALL ignore rN_pushin while rN_gnt is low.

Reset
REQ-025 SHALL, while reset is low, force IDLE, priority to requester 0, FIFO empty, beat counter 0, and all outputs (gnts, p_*, o_*, err, counters) to 0.
REQ-026 SHALL, on reset mid-frame, discard the partial frame; the perm core shares the same reset.

Configuration
REQ-027 SHALL, with PERM_ARB_STATS_EN defined, add outputs frames0 and frames1 (16-bit each): the count of frames completed per requester, incremented at the beat-7 push, wrapping modulo 2^16, and reset to 0.
REQ-028 SHALL, without PERM_ARB_STATS_EN, omit those ports and counters; all other behaviour is identical.

Verification
REQ-029 SHALL cover single frame: r0_req, then 8 beats of din 0x60a636261, 0, 0, 0, 0, 0x8000000000000000000000, 0, 0 -> p_dix 0..7 one cycle after each beat; r0_gnt drops after beat 7.
REQ-030 SHALL cover contention: both requests from reset -> r0 granted first, r1 granted with no bubble after r0's beat 7, then r0 again.
REQ-031 SHALL cover gapped input: r1 pushes 8 beats with 3 idle cycles inserted -> p_dix stays contiguous 0..7 and the grant is held throughout.
REQ-032 SHALL cover FIFO full: 4 frames granted with no p_pushout -> fifth request not granted until a result frame with doutix=7 pops a tag.
REQ-033 SHALL cover result routing: frames r0, r1 queued; perm returns two frames -> o_pushout0 for the first 8 beats, o_pushout1 for the next 8; err=0.
REQ-034 SHALL cover error and reset: p_pushout with the FIFO empty -> err=1, no o_pushout; reset low mid-frame -> all outputs 0 and err=0.
